mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer that shares one single-ported, handshaked backing memory between the pipeline's instruction-fetch port and data (MEM-stage) port. It serialises requests, holds the memory command stable until the memory acknowledges, and returns one-cycle acknowledges with read data to the winning port. Its stall outputs feed the pipeline's PC-write and stage-stall logic. Data accesses have priority, with a starvation guard for fetch.

## Interface
- ADDR_W, 32, address width of both ports and memory
- DATA_W, 32, data width
- STARVE_MAX, 2, consecutive fetch losses after which fetch wins a tie
- TIMEOUT, 64, memory-ack watchdog limit in cycles (used only with MEM_ARB_TIMEOUT_EN)

Ports (all outputs registered unless noted):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, level; held with if_addr_i stable until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetch data, valid with if_ack_o, held afterwards
- if_stall_o  out  1  combinational: if_req_i & ~if_ack_o
- dm_req_i  in  1  data request, level; held with dm_we_i, dm_addr_i and dm_wdata_i stable until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_ack_o  out  1  one-cycle data completion pulse
- dm_rdata_o  out  DATA_W  read data, valid with dm_ack_o; unchanged on write acks
- dm_stall_o  out  1  combinational: dm_req_i & ~dm_ack_o
- mem_req_o  out  1  memory command valid
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion; mem_rdata_i valid in the same cycle
- mem_rdata_i  in  DATA_W  memory read data
- err_o  out  1  sticky timeout flag

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: mem_req_o = 1, command held stable.
  - RESP: pulse the owner's ack_o.
- IDLE:
  - If any request is sampled, latch the owner and command, then go to BUSY.
  - If none is sampled, stay in IDLE.
- Arbitration:
  - Data only → data wins.
  - Fetch only → fetch wins.
  - Both → data wins unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments (saturating) when data wins while if_req_i = 1.
  - Clears when fetch is granted.
- BUSY:
  - On mem_ack_i: capture mem_rdata_i into the owner's rdata register (reads only), drop mem_req_o, go to RESP.
- RESP:
  - Owner's ack_o = 1 for exactly one cycle, then go to IDLE.
- mem_ack_i outside BUSY is ignored.
- A request that changes before its ack is a protocol violation; behaviour is undefined.
- Reset:
  - All outputs 0, rdata registers 0, state IDLE, starve_cnt 0, err_o 0.
  - Reset asserted mid-transaction drops mem_req_o immediately and abandons the transaction; no ack is issued.

## Timing
- Request sampled at IDLE edge 0:
  - mem_req_o = 1 from cycle 1.
  - mem_ack_i arrives in cycle 1+k (k ≥ 0; zero-wait memory allowed).
  - x_ack_o = 1 in cycle 2+k.
  - IDLE in cycle 3+k.
- Minimum request-to-ack latency is 2 cycles.
- Throughput: at most one transaction per 3 cycles.
- The requester drops or changes its request at the edge ending the ack cycle. The arbiter samples it at the next IDLE edge, so no spurious re-grant occurs.
- Both requests pending continuously with STARVE_MAX = 2: grants run D, D, F, D, D, F…

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A cycle counter clears on entry to BUSY.
  - If it reaches TIMEOUT with no mem_ack_i: drop mem_req_o, go to RESP, ack the owner with rdata = 0xDEAD_BEEF (reads only; writes leave rdata unchanged), and set err_o.
  - err_o stays set until reset.
  - An ack arriving in the same cycle the counter reaches TIMEOUT counts as a normal completion.
- MEM_ARB_TIMEOUT_EN undefined:
  - BUSY waits indefinitely.
  - err_o is tied to 0.
  - No counter logic is present.

## Test plan
- Single fetch: if_req_i = 1, if_addr_i = 0x40, memory acks 1 cycle after mem_req_o with 0x00A00093 → mem_addr_o = 0x40, mem_we_o = 0; if_ack_o pulses exactly once, 3 cycles after the request was sampled; if_rdata_o = 0x00A00093; if_stall_o high until the ack cycle.
- Data write, zero-wait memory (k = 0): dm_req_i = 1, dm_we_i = 1, addr 0x100, wdata 0x1234 → mem_we_o = 1, mem_wdata_o = 0x1234; dm_ack_o 2 cycles after sampling; dm_rdata_o unchanged.
- Simultaneous requests held continuously, STARVE_MAX = 2 → mem_addr_o grant order D, D, F, D, D, F; starve_cnt clears after each F.
- Reset mid-BUSY: assert rst_i low while mem_req_o = 1 → mem_req_o goes low immediately, before the next edge; no ack pulse; after release, the next request is served normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT = 64, memory never acks a read → after 64 cycles, dm_ack_o pulses with dm_rdata_o = 0xDEADBEEF; err_o = 1 and remains 1 through later successful transactions.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one handshaked memory between fetch and data ports; data has priority, fetch gets a starvation guard.
// Latency: req sampled -> ack in 2+k cycles, 1 txn per 3 cycles; backpressure via if/dm_stall_o; watchdog via MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = data port owns the transaction
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [SW-1:0]     starve_q, starve_d;

  logic starved;
  logic grant_dm;
  logic grant_if;

  assign starved  = (starve_q == SW'(STARVE_MAX));
  assign grant_dm = dm_req_i & ~(if_req_i & starved);
  assign grant_if = if_req_i & ~grant_dm;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    starve_d    = starve_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_dm || grant_if) begin
          state_d     = BUSY;
          owner_d     = grant_dm;
          mem_req_d   = 1'b1;
          mem_we_d    = grant_dm & dm_we_i;
          mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
          mem_wdata_d = grant_dm ? dm_wdata_i : '0;
`ifdef MEM_ARB_TIMEOUT_EN
          tmo_d       = '0;
`endif
          if (grant_if) begin
            starve_d = '0;
          end else if (if_req_i && !starved) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if_ack_d  = ~owner_q;
          dm_ack_d  = owner_q;
          if (!mem_we_q) begin
            if (owner_q) dm_rdata_d = mem_rdata_i;
            else         if_rdata_d = mem_rdata_i;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          // Complete with a poison word so the pipeline can drain instead of hanging.
          state_d   = RESP;
          mem_req_d = 1'b0;
          if_ack_d  = ~owner_q;
          dm_ack_d  = owner_q;
          err_d     = 1'b1;
          if (!mem_we_q) begin
            if (owner_q) dm_rdata_d = DATA_W'(32'hDEAD_BEEF);
            else         if_rdata_d = DATA_W'(32'hDEAD_BEEF);
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      starve_q    <= starve_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // Watchdog compiled out: the flag is constant 0 and TIMEOUT has no effect.
  assign err_o = (TIMEOUT < 0);
`endif

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;

endmodule
